// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// findWinner scans from a priority pointer and can skip the current holder.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns {found, index} of the first set request at or after ptr (wrapping).
  function automatic logic [ID_W:0] findWinner(
    input logic [NREQ-1:0] reqVec,
    input logic [ID_W-1:0] ptr,
    input logic            skipEn,
    input logic [ID_W-1:0] skipId
  );
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && reqVec[idx] && !(skipEn && (idx == skipId))) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// Combinational 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder2to4
  import arb_pkg::*;
(
  input  logic [ID_W-1:0] id,
  input  logic            en,
  output logic [NREQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[id] = 1'b1;
  end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter for four requesters with a per-grant hold limit.
// All outputs are registered; gnt is the decoded next grant captured in a flop.
module rr_arb4_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  localparam int            HW        = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            valid_q, valid_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [ID_W:0]   winResult;
  logic            winFound;
  logic [ID_W-1:0] winId;
  logic            grantNew;

  // While granting, the holder is always excluded so rotation never re-picks it.
  assign winResult = findWinner(req, ptr_q, state_q == GRANT, id_q);
  assign winFound  = winResult[ID_W];
  assign winId     = winResult[ID_W-1:0];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    id_d     = id_q;
    valid_d  = valid_q;
    grantNew = 1'b0;
    case (state_q)
      IDLE: begin
        if (winFound) grantNew = 1'b1;
      end
      GRANT: begin
        if (!req[id_q]) begin
          if (winFound) begin
            grantNew = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end else if (winFound) begin
          grantNew = 1'b1;
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grantNew) begin
      state_d = GRANT;
      id_d    = winId;
      valid_d = 1'b1;
      ptr_d   = winId + ID_W'(1);
      hold_d  = '0;
    end
  end

  decoder2to4 u_dec (
    .id (id_d),
    .en (valid_d),
    .y  (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Self-checking bench for rr_arb4_ctrl (MAX_HOLD = 4): a reference model queues the
// expected grant per cycle, plus directed spot checks for the key scenarios.
module tb_rr_arb4_ctrl;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  exp_t  expQ[$];
  int    nAsserts;
  int    nFails;
  string stepName;

  int mPtr;
  int mCur;
  int mCnt;
  bit mValid;

  rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pickFrom(input logic [3:0] r, input int p, input int skip);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p + i) % 4;
      if (r[k] && k != skip) return k;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      mValid = 0; mCur = 0; mCnt = 0; mPtr = 0;
    end else if (!mValid) begin
      w = pickFrom(r, mPtr, -1);
      if (w >= 0) begin
        mValid = 1; mCur = w; mCnt = 0; mPtr = (w + 1) % 4;
      end
    end else begin
      w = pickFrom(r, mPtr, mCur);
      if (!r[mCur] || mCnt == MAX_HOLD - 1) begin
        if (w >= 0) begin
          mCur = w; mCnt = 0; mPtr = (w + 1) % 4;
        end else if (!r[mCur]) begin
          mValid = 0; mCur = 0; mCnt = 0;
        end else begin
          mCnt = 0;
        end
      end else begin
        mCnt = mCnt + 1;
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      nAsserts++;
      nFails++;
      $display("[TB] FAIL %s scoreboard empty: observed gnt=%b, expected an entry", stepName, gnt);
      return;
    end
    e = expQ.pop_front();
    nAsserts++;
    assert (gnt === e.gnt) else begin
      nFails++;
      $error("[TB] FAIL %s gnt: observed %b expected %b", stepName, gnt, e.gnt);
    end
    nAsserts++;
    assert (gnt_id === e.id) else begin
      nFails++;
      $error("[TB] FAIL %s gnt_id: observed %0d expected %0d", stepName, gnt_id, e.id);
    end
    nAsserts++;
    assert (gnt_valid === e.v) else begin
      nFails++;
      $error("[TB] FAIL %s gnt_valid: observed %b expected %b", stepName, gnt_valid, e.v);
    end
    nAsserts++;
    assert ($countones(gnt) <= 1) else begin
      nFails++;
      $error("[TB] FAIL %s onehot: observed %b expected at most one bit", stepName, gnt);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    modelStep(r, rs);
    e.gnt = mValid ? (4'b0001 << mCur) : 4'b0000;
    e.id  = 2'(mCur);
    e.v   = mValid;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkDirect(input string tag, input logic [3:0] expGnt, input logic [1:0] expId,
                             input logic expV);
    nAsserts++;
    assert (gnt === expGnt && gnt_id === expId && gnt_valid === expV) else begin
      nFails++;
      $error("[TB] FAIL %s: observed gnt=%b id=%0d v=%b expected gnt=%b id=%0d v=%b",
             tag, gnt, gnt_id, gnt_valid, expGnt, expId, expV);
    end
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    mPtr = 0; mCur = 0; mCnt = 0; mValid = 0;
    rst = 1'b1;
    req = 4'b0000;

    stepName = "reset";
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b1111, 1'b1);
      checkDirect("reset_hold", 4'b0000, 2'd0, 1'b0);
    end

    stepName = "single";
    applyStimulus(4'b0000, 1'b0);
    checkDirect("idle_no_req", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkDirect("single_grant", 4'b0100, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkDirect("single_release", 4'b0000, 2'd0, 1'b0);

    stepName = "round_robin";
    applyStimulus(4'b0000, 1'b1);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(4'b1111, 1'b0);
      checkDirect("rr_sequence", 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1);
    end

    stepName = "handoff";
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0011, 1'b0);
    checkDirect("handoff_first", 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    checkDirect("handoff_next", 4'b0010, 2'd1, 1'b1);

    stepName = "sole_expiry";
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0001, 1'b0);
      checkDirect("sole_hold", 4'b0001, 2'd0, 1'b1);
    end

    stepName = "mid_reset";
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkDirect("mid_granted", 4'b0100, 2'd2, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    checkDirect("mid_reset_drop", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkDirect("mid_ptr_restart", 4'b0001, 2'd0, 1'b1);

    // Random traffic exercises non-holder request changes and occasional resets.
    stepName = "random";
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
